// File: rtl/iirseq_pkg.sv
// iirseq_pkg: shared definitions for the iirseq all-pole IIR filter.
// Holds the FSM state encoding and the saturation helper used when the
// build defines IIRSEQ_SAT_EN.
package iirseq_pkg;

    // FSM states: wait for a sample, step the shared multiplier, present y.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MAC  = 2'd1,
        S_OUT  = 2'd2
    } state_e;

    // Working width for the saturation helper; the accumulator must fit in it.
    localparam int SAT_W = 64;

    // Clamp a signed value to the range of a dw-bit two's-complement number.
    function automatic logic signed [SAT_W-1:0] sat_dw(
        input logic signed [SAT_W-1:0] v,
        input int                      dw
    );
        logic signed [SAT_W-1:0] hi;
        logic signed [SAT_W-1:0] lo;
        hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (dw - 1));
        if (v > hi) begin
            return hi;
        end else if (v < lo) begin
            return lo;
        end else begin
            return v;
        end
    endfunction

endpackage

// File: rtl/iirseq_hist.sv
// iirseq_hist: N-deep history of past outputs y[n-1..n-N].
// Entry 1 is the most recent output. A push shifts every entry one place
// older and loads din into entry 1. The read port is combinational and
// indexed 1..N; any other index reads zero.
module iirseq_hist
    import iirseq_pkg::*;
#(
    parameter int DW = 16,
    parameter int N  = 8,
    parameter int KW = 4
) (
    input  logic          clk,
    input  logic          clear,
    input  logic          push,
    input  logic [DW-1:0] din,
    input  logic [KW-1:0] rd_idx,
    output logic [DW-1:0] rd_data
);

    logic [DW-1:0] hist_q [1:N];
    logic [DW-1:0] hist_d [1:N];

    // Next history contents: shift older by one place on push.
    always_comb begin
        hist_d = hist_q;
        if (push) begin
            hist_d[1] = din;
            for (int i = 2; i <= N; i++) begin
                hist_d[i] = hist_q[i-1];
            end
        end
    end

    // History register; clear zeroes every entry and wins over push.
    always_ff @(posedge clk) begin
        if (clear) begin
            for (int i = 1; i <= N; i++) begin
                hist_q[i] <= '0;
            end
        end else begin
            hist_q <= hist_d;
        end
    end

    // Read port: select entry rd_idx, zero when out of range.
    always_comb begin
        rd_data = '0;
        for (int i = 1; i <= N; i++) begin
            if (rd_idx == KW'(i)) begin
                rd_data = hist_q[i];
            end
        end
    end

endmodule

// File: rtl/iirseq.sv
// iirseq: all-pole fixed-point IIR filter y[n] = x[n] - sum a_k*y[n-k].
// One multiplier is time-shared across the N taps by a small FSM:
// IDLE accepts x, MAC runs exactly N multiply-subtract steps, OUT holds y
// until the consumer takes it, then y is pushed into the history.
// Handshake: a transfer happens on a rising edge where valid & ready are
// both high; y and out_valid stay stable until that transfer happens.
// Optional feature: define IIRSEQ_SAT_EN to saturate the result to DW bits
// instead of wrapping it.
module iirseq
    import iirseq_pkg::*;
#(
    parameter int              DW   = 16,
    parameter int              ACCW = 40,
    parameter int              N    = 8,
    parameter int              FRAC = 8,
    parameter logic [DW*N-1:0] A    = '0
) (
    input  logic          clk,
    input  logic          clear,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] x,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] y
);

    localparam int KW = $clog2(N + 1);

    state_e               state_q, state_d;
    logic [KW-1:0]        k_q, k_d;
    logic [ACCW-1:0]      acc_q, acc_d;
    logic [DW-1:0]        y_q, y_d;

    logic [DW-1:0]        coef_k;
    logic [DW-1:0]        hist_k;
    logic signed [2*DW-1:0] prod;
    logic [ACCW-1:0]      prod_ext;
    logic [ACCW-1:0]      x_ext;
    logic [ACCW-1:0]      acc_mac;
    logic signed [ACCW-1:0] res_full;
    logic [DW-1:0]        y_res;
    logic                 hist_push;

    // Coefficient a_k for the current tap; zero outside 1..N.
    always_comb begin
        coef_k = '0;
        for (int i = 1; i <= N; i++) begin
            if (k_q == KW'(i)) begin
                coef_k = A[(i-1)*DW +: DW];
            end
        end
    end

    // Datapath: full-width product, accumulator step and scaled result.
    always_comb begin
        prod     = $signed(coef_k) * $signed(hist_k);
        prod_ext = {{(ACCW-2*DW){prod[2*DW-1]}}, prod};
        x_ext    = {{(ACCW-DW){x[DW-1]}}, x} << FRAC;
        acc_mac  = acc_q - prod_ext;
        res_full = $signed(acc_mac) >>> FRAC;
    end

    // Reduce the scaled result to DW bits for y and the history.
    always_comb begin
`ifdef IIRSEQ_SAT_EN
        y_res = DW'(sat_dw(SAT_W'(res_full), DW));
`else
        y_res = DW'(res_full);
`endif
    end

    // FSM next state, tap counter, accumulator and output register.
    always_comb begin
        state_d   = state_q;
        k_d       = k_q;
        acc_d     = acc_q;
        y_d       = y_q;
        hist_push = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (in_valid && !clear) begin
                    acc_d   = x_ext;
                    k_d     = KW'(1);
                    state_d = S_MAC;
                end
            end
            S_MAC: begin
                acc_d = acc_mac;
                k_d   = k_q + KW'(1);
                if (k_q == KW'(N)) begin
                    y_d     = y_res;
                    state_d = S_OUT;
                end
            end
            S_OUT: begin
                if (out_ready) begin
                    hist_push = 1'b1;
                    state_d   = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State registers; clear abandons any sample in flight.
    always_ff @(posedge clk) begin
        if (clear) begin
            state_q <= S_IDLE;
            k_q     <= '0;
            acc_q   <= '0;
            y_q     <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            acc_q   <= acc_d;
            y_q     <= y_d;
        end
    end

    iirseq_hist #(
        .DW (DW),
        .N  (N),
        .KW (KW)
    ) u_hist (
        .clk     (clk),
        .clear   (clear),
        .push    (hist_push),
        .din     (y_q),
        .rd_idx  (k_q),
        .rd_data (hist_k)
    );

    assign in_ready  = (state_q == S_IDLE) && !clear;
    assign out_valid = (state_q == S_OUT);
    assign y         = y_q;

endmodule
